imem_fetch_ctrl: RTL and testbench

Instruction fetch controller that sequences the byte-addressed, combinational-read instruction ROM. It owns the fetch PC and issues one word-aligned address per cycle. The fetched words go into a small prefetch FIFO that feeds decode through a valid/ready handshake. Branch/jump redirects flush the FIFO and restart fetch at the target with one cycle of latency.

---
 rtl/imem_fetch_ctrl.sv | 73 +++++++
 tb/tb_imem_fetch_ctrl.sv | 126 ++++++++++++
 2 files changed

// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: instruction fetch sequencer with prefetch FIFO and redirect flush
module imem_fetch_ctrl #(
    parameter int          DEPTH    = 4,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    output logic [15:0]              o_mem_addr,
    input  logic [31:0]              i_mem_data,
    input  logic                     i_enable,
    input  logic                     i_redirect_valid,
    input  logic [15:0]              i_redirect_pc,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [31:0]              o_instr,
    output logic [15:0]              o_pc,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_misalign
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [15:0]   pc;
    logic [15:0]   fpc  [DEPTH];
    logic [31:0]   fins [DEPTH];
    logic [AW-1:0] rd, wr;
    logic [LW-1:0] level;
    logic          pop, space, push, drain;

    assign o_mem_addr = i_redirect_valid ? {i_redirect_pc[15:2], 2'b00} : pc;
    assign o_valid    = level != '0;
    assign o_level    = level;
    assign o_instr    = fins[rd];
    assign o_pc       = fpc[rd];
    assign pop        = o_valid & i_ready;
    assign space      = (level < LW'(DEPTH)) | pop;
    assign push       = i_enable & space;
    // Emptying pop leaves the head pointer on the last entry so o_instr/o_pc hold
    assign drain      = pop & ~push & (level == LW'(1));

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            pc       <= RESET_PC;
            rd       <= '0;
            wr       <= '0;
            level    <= '0;
            o_misalign <= 1'b0;
            for (int k = 0; k < DEPTH; k++) begin
                fpc[k]  <= '0;
                fins[k] <= '0;
            end
        end else if (i_redirect_valid) begin
            wr    <= rd + AW'(i_enable);
            level <= LW'(i_enable);
            pc    <= o_mem_addr + (i_enable ? 16'd4 : 16'd0);
            if (i_enable) begin
                fpc[rd]  <= o_mem_addr;
                fins[rd] <= i_mem_data;
            end
            if (i_redirect_pc[1:0] != 2'b00)
                o_misalign <= 1'b1;
        end else begin
            if (push) begin
                fpc[wr]  <= pc;
                fins[wr] <= i_mem_data;
                pc       <= pc + 16'd4;
            end
            rd    <= rd + AW'(pop & ~drain);
            wr    <= wr + AW'(push) - AW'(drain);
            level <= level + LW'(push) - LW'(pop);
        end
    end
endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb_imem_fetch_ctrl: directed self-checking bench for imem_fetch_ctrl
module tb_imem_fetch_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] mem_addr;
    logic [31:0] mem_data;
    logic        enable, redirect_valid, ready;
    logic [15:0] redirect_pc;
    logic        valid, misalign;
    logic [31:0] instr;
    logic [15:0] pc;
    logic [2:0]  level;
    int          total = 0;
    int          passed = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [15:0] a);
        return a == 16'h0000 ? 32'h00000013 :
               a == 16'h0004 ? 32'h00100093 :
               a == 16'h0008 ? 32'h00200113 : {16'hC0DE, a};
    endfunction

    assign mem_data = rom(mem_addr);

    imem_fetch_ctrl #(.DEPTH(4), .RESET_PC(16'h0000)) dut (
        .i_clk(clk), .i_reset(rst), .o_mem_addr(mem_addr), .i_mem_data(mem_data),
        .i_enable(enable), .i_redirect_valid(redirect_valid), .i_redirect_pc(redirect_pc),
        .o_valid(valid), .i_ready(ready), .o_instr(instr), .o_pc(pc),
        .o_level(level), .o_misalign(misalign)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    initial begin
        rst = 1'b1; enable = 1'b1; ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        tick; tick;
        chk("rst_valid", valid, 0);
        chk("rst_level", level, 0);
        chk("rst_pc", pc, 0);
        chk("rst_instr", instr, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_mis", misalign, 0);
        rst = 1'b0;
        // straight-line fetch, consumer always ready
        tick; chk("t1_pc0", pc, 16'h0000); chk("t1_i0", instr, 32'h00000013); chk("t1_v0", valid, 1);
        tick; chk("t1_pc1", pc, 16'h0004); chk("t1_i1", instr, 32'h00100093); chk("t1_v1", valid, 1);
        tick; chk("t1_pc2", pc, 16'h0008); chk("t1_i2", instr, 32'h00200113); chk("t1_lv2", level, 1);
        // fill with consumer stalled
        rst = 1'b1; #1;
        chk("t2_rst_lv", level, 0);
        ready = 1'b0;
        tick; rst = 1'b0;
        tick; chk("t2_lv1", level, 1);
        tick; chk("t2_lv2", level, 2);
        tick; chk("t2_lv3", level, 3);
        tick; chk("t2_lv4", level, 4); chk("t2_addr4", mem_addr, 16'h0010);
        tick; chk("t2_lv4h", level, 4); chk("t2_addrh", mem_addr, 16'h0010);
        ready = 1'b1; #1;
        chk("t2_h0", pc, 16'h0000);
        tick; chk("t2_h1", pc, 16'h0004); chk("t2_v1", valid, 1);
        tick; chk("t2_h2", pc, 16'h0008);
        tick; chk("t2_h3", pc, 16'h000C);
        tick; chk("t2_h4", pc, 16'h0010); chk("t2_lvf", level, 4);
        // redirect with simultaneous pop
        redirect_valid = 1'b1; redirect_pc = 16'h0040; #1;
        chk("t3_addr", mem_addr, 16'h0040);
        chk("t3_popped", pc, 16'h0010);
        chk("t3_vpop", valid, 1);
        tick; redirect_valid = 1'b0; #1;
        chk("t3_lv", level, 1);
        chk("t3_pc", pc, 16'h0040);
        chk("t3_instr", instr, 32'hC0DE0040);
        chk("t3_addr2", mem_addr, 16'h0044);
        chk("t3_mis", misalign, 0);
        // misaligned target
        redirect_valid = 1'b1; redirect_pc = 16'h0042; #1;
        chk("t4_addr", mem_addr, 16'h0040);
        tick; redirect_valid = 1'b0; #1;
        chk("t4_mis", misalign, 1);
        chk("t4_pc", pc, 16'h0040);
        chk("t4_lv", level, 1);
        // wrap-around
        redirect_valid = 1'b1; redirect_pc = 16'hFFF8;
        tick; redirect_valid = 1'b0; #1;
        chk("t5_pc0", pc, 16'hFFF8); chk("t5_mis", misalign, 1);
        tick; chk("t5_pc1", pc, 16'hFFFC);
        tick; chk("t5_pc2", pc, 16'h0000); chk("t5_i2", instr, 32'h00000013);
        tick; chk("t5_pc3", pc, 16'h0004); chk("t5_i3", instr, 32'h00100093);
        // fetch disabled: drain then hold
        enable = 1'b0;
        tick; chk("en_lv0", level, 0); chk("en_v0", valid, 0); chk("en_hold", pc, 16'h0004);
        chk("en_addr", mem_addr, 16'h0008);
        tick; chk("en_addr2", mem_addr, 16'h0008); chk("en_lv0b", level, 0);
        enable = 1'b1;
        tick; chk("en_pc", pc, 16'h0008); chk("en_i", instr, 32'h00200113); chk("en_v", valid, 1);
        // redirect while disabled
        enable = 1'b0; redirect_valid = 1'b1; redirect_pc = 16'h0080;
        tick; redirect_valid = 1'b0; #1;
        chk("rd_lv", level, 0); chk("rd_addr", mem_addr, 16'h0080);
        enable = 1'b1;
        tick; chk("rd_pc", pc, 16'h0080); chk("rd_lv1", level, 1);
        // reset mid-operation with redirect pending
        ready = 1'b0;
        tick; tick; chk("t6_lv3", level, 3);
        rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 16'h0100; #1;
        chk("t6_v", valid, 0); chk("t6_lv", level, 0);
        redirect_valid = 1'b0; #1;
        chk("t6_addr", mem_addr, 16'h0000); chk("t6_mis", misalign, 0);
        tick; chk("t6_lvr", level, 0);
        rst = 1'b0; ready = 1'b1;
        tick; chk("t6_pc", pc, 16'h0000); chk("t6_i", instr, 32'h00000013);
        chk("t6_v1", valid, 1); chk("t6_mis2", misalign, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
